// File: rtl/dice_roll_engine.sv
// Dice-game controller: free-running die counters plus a come-out/point sequencer
// with a bounded roll budget. A rising edge on the roll button latches all dice at once.
module dice_roll_engine #(
    parameter int FACES     = 6,
    parameter int NUM_DICE  = 2,
    parameter int MAX_ROLLS = 3,
    parameter int WIN1      = 7,
    parameter int WIN2      = 11,
    parameter int LOSE1     = 2,
    parameter int LOSE2     = 3,
    parameter int LOSE3     = 12,
    localparam int DW = $clog2(FACES + 1),
    localparam int SW = $clog2(NUM_DICE * FACES + 1),
    localparam int RW = $clog2(MAX_ROLLS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   roll_btn_i,
    output logic [NUM_DICE*DW-1:0] dice_out_o,
    output logic [SW-1:0]          sum_o,
    output logic [SW-1:0]          point_o,
    output logic                   point_valid_o,
    output logic [RW-1:0]          rolls_left_o,
    output logic                   roll_ready_o,
    output logic                   win_o,
    output logic                   lose_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL, S_DONE} state_t;

    state_t                 state_q;
    logic                   btn_q;
    logic [DW-1:0]          cnt_q [NUM_DICE];
    logic [DW-1:0]          cnt_d [NUM_DICE];
    logic [NUM_DICE*DW-1:0] cnt_flat;
    logic [SW-1:0]          cnt_sum;
    logic [NUM_DICE*DW-1:0] dice_q;
    logic [SW-1:0]          sum_q;
    logic [SW-1:0]          point_q;
    logic                   pv_q;
    logic [RW-1:0]          rl_q;
    logic                   win_q;
    logic                   lose_q;
    logic                   roll_edge;
    logic                   win_sum, lose_sum, eval_win, eval_lose, comeout_undec;

    // Advance a die by one step plus an optional carry, wrapping back into 1..FACES.
    function automatic logic [DW-1:0] die_step(input logic [DW-1:0] v, input logic carry);
        logic [DW:0] t;
        t = {1'b0, v} + (DW+1)'(1) + {{DW{1'b0}}, carry};
        if (t > (DW+1)'(FACES))
            t = t - (DW+1)'(FACES);
        return DW'(t);
    endfunction

    always_comb begin
        cnt_d[0] = die_step(cnt_q[0], 1'b0);
        for (int i = 1; i < NUM_DICE; i++)
            cnt_d[i] = die_step(cnt_q[i], cnt_q[i-1] == DW'(FACES));
    end

    always_comb begin
        cnt_flat = '0;
        cnt_sum  = '0;
        for (int i = 0; i < NUM_DICE; i++) begin
            cnt_flat[i*DW +: DW] = cnt_q[i];
            cnt_sum              = cnt_sum + SW'(cnt_q[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_DICE; i++)
                cnt_q[i] <= DW'(1);
        end else begin
            for (int i = 0; i < NUM_DICE; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    assign roll_edge = roll_btn_i & ~btn_q;

    // Outcome of the roll held in sum_q; an undecided roll with no budget left loses.
    always_comb begin
        win_sum       = 1'b0;
        lose_sum      = 1'b0;
        eval_win      = 1'b0;
        eval_lose     = 1'b0;
        comeout_undec = 1'b0;
        if (!pv_q) begin
            win_sum  = (sum_q == SW'(WIN1)) || (sum_q == SW'(WIN2));
            lose_sum = !win_sum && ((sum_q == SW'(LOSE1)) || (sum_q == SW'(LOSE2)) ||
                                    (sum_q == SW'(LOSE3)));
            comeout_undec = !win_sum && !lose_sum;
        end else begin
            win_sum  = (sum_q == point_q);
            lose_sum = !win_sum && (sum_q == SW'(WIN1));
        end
        eval_win  = win_sum;
        eval_lose = lose_sum || (!win_sum && !lose_sum && rl_q == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            btn_q   <= 1'b0;
            dice_q  <= '0;
            sum_q   <= '0;
            point_q <= '0;
            pv_q    <= 1'b0;
            rl_q    <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            btn_q <= roll_btn_i;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q <= S_WAIT;
                        win_q   <= 1'b0;
                        lose_q  <= 1'b0;
                        point_q <= '0;
                        pv_q    <= 1'b0;
                        dice_q  <= '0;
                        sum_q   <= '0;
                        rl_q    <= RW'(MAX_ROLLS);
                    end
                end
                S_WAIT: begin
                    if (roll_edge) begin
                        state_q <= S_EVAL;
                        dice_q  <= cnt_flat;
                        sum_q   <= cnt_sum;
                        rl_q    <= rl_q - RW'(1);
                    end
                end
                S_EVAL: begin
                    if (comeout_undec) begin
                        point_q <= sum_q;
                        pv_q    <= 1'b1;
                    end
                    if (eval_win) begin
                        win_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else if (eval_lose) begin
                        lose_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dice_out_o    = dice_q;
    assign sum_o         = sum_q;
    assign point_o       = point_q;
    assign point_valid_o = pv_q;
    assign rolls_left_o  = rl_q;
    assign win_o         = win_q;
    assign lose_o        = lose_q;
    assign roll_ready_o  = (state_q == S_WAIT);
    assign busy_o        = (state_q == S_WAIT) || (state_q == S_EVAL);

endmodule

// File: tb/tb_dice_roll_engine.sv
// Directed bench for dice_roll_engine with default parameters (6 faces, 2 dice, 3 rolls).
module tb_dice_roll_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       btn;
    logic [5:0] dice;
    logic [3:0] sum;
    logic [3:0] point;
    logic       pv;
    logic [1:0] rolls;
    logic       ready;
    logic       win;
    logic       lose;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    dice_roll_engine dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .roll_btn_i   (btn),
        .dice_out_o   (dice),
        .sum_o        (sum),
        .point_o      (point),
        .point_valid_o(pv),
        .rolls_left_o (rolls),
        .roll_ready_o (ready),
        .win_o        (win),
        .lose_o       (lose),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dice(input string tag, input int d0, input int d1);
        chk(tag, {26'd0, dice}, 32'((d1 << 3) | d0));
    endtask

    task automatic tick;
        @(posedge clk);
        ecnt++;
        #1;
    endtask

    // Assert reset, release it between edges, then pulse start on edge 1.
    task automatic restart;
        rst_n = 1'b0;
        start = 1'b0;
        btn   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ecnt  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic roll_at(input int k);
        if (ecnt > k - 1)
            chk("sched", 32'(ecnt), 32'(k - 1));
        while (ecnt < k - 1)
            tick();
        btn = 1'b1;
        tick();
        btn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        btn   = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            start = ~start;
            btn   = ~btn;
        end
        chk("rst_dice",  {26'd0, dice}, 0);
        chk("rst_sum",   {28'd0, sum}, 0);
        chk("rst_point", {28'd0, point}, 0);
        chk("rst_pv",    {31'd0, pv}, 0);
        chk("rst_rolls", {30'd0, rolls}, 0);
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_win",   {31'd0, win}, 0);
        chk("rst_lose",  {31'd0, lose}, 0);
        chk("rst_busy",  {31'd0, busy}, 0);

        // Come-out natural 7, then a button press in DONE is ignored.
        restart();
        chk("st_ready", {31'd0, ready}, 1);
        chk("st_rolls", {30'd0, rolls}, 3);
        chk("st_busy",  {31'd0, busy}, 1);
        roll_at(9);
        chk_dice("g1_dice", 3, 4);
        chk("g1_sum",   {28'd0, sum}, 7);
        chk("g1_rolls", {30'd0, rolls}, 2);
        chk("g1_evbusy", {31'd0, busy}, 1);
        chk("g1_evrdy", {31'd0, ready}, 0);
        tick();
        chk("g1_win",  {31'd0, win}, 1);
        chk("g1_lose", {31'd0, lose}, 0);
        chk("g1_busy", {31'd0, busy}, 0);
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
        chk_dice("g1_hold", 3, 4);
        chk("g1_rolls2", {30'd0, rolls}, 2);

        // Come-out 12 loses; a new start clears the result.
        restart();
        roll_at(6);
        chk_dice("g2_dice", 6, 6);
        chk("g2_sum", {28'd0, sum}, 12);
        tick();
        chk("g2_lose", {31'd0, lose}, 1);
        chk("g2_win",  {31'd0, win}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("g2_clrl", {31'd0, lose}, 0);
        chk("g2_clrw", {31'd0, win}, 0);
        chk("g2_rl",   {30'd0, rolls}, 3);
        chk("g2_sum0", {28'd0, sum}, 0);
        chk("g2_rdy",  {31'd0, ready}, 1);

        // Point 6, two undecided rolls, budget exhausted.
        restart();
        roll_at(3);
        chk("g3_sum1", {28'd0, sum}, 6);
        tick();
        chk("g3_point", {28'd0, point}, 6);
        chk("g3_pv",    {31'd0, pv}, 1);
        chk("g3_rdy1",  {31'd0, ready}, 1);
        chk("g3_rl1",   {30'd0, rolls}, 2);
        roll_at(8);
        chk("g3_sum2", {28'd0, sum}, 5);
        tick();
        chk("g3_rl2",  {30'd0, rolls}, 1);
        chk("g3_rdy2", {31'd0, ready}, 1);
        chk("g3_nol",  {31'd0, lose}, 0);
        roll_at(10);
        chk("g3_sum3", {28'd0, sum}, 9);
        tick();
        chk("g3_lose", {31'd0, lose}, 1);
        chk("g3_win",  {31'd0, win}, 0);
        chk("g3_rl3",  {30'd0, rolls}, 0);

        // Point 6 made.
        restart();
        roll_at(3);
        tick();
        roll_at(14);
        chk_dice("g4_dice", 2, 4);
        chk("g4_sum", {28'd0, sum}, 6);
        tick();
        chk("g4_win",  {31'd0, win}, 1);
        chk("g4_lose", {31'd0, lose}, 0);

        // Seven-out in point phase.
        restart();
        roll_at(3);
        tick();
        roll_at(9);
        chk("g5_sum", {28'd0, sum}, 7);
        tick();
        chk("g5_lose", {31'd0, lose}, 1);
        chk("g5_win",  {31'd0, win}, 0);

        // Held button rolls once; start in WAIT is ignored.
        restart();
        btn = 1'b1;
        repeat (20) tick();
        btn = 1'b0;
        chk("g6_rl",    {30'd0, rolls}, 2);
        chk("g6_pv",    {31'd0, pv}, 1);
        chk("g6_point", {28'd0, point}, 4);
        chk("g6_rdy",   {31'd0, ready}, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("g6_strl", {30'd0, rolls}, 2);
        chk("g6_stpv", {31'd0, pv}, 1);
        chk("g6_strd", {31'd0, ready}, 1);

        // Asynchronous reset while in EVAL.
        restart();
        roll_at(3);
        chk("g7_busy", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("g7_dice", {26'd0, dice}, 0);
        chk("g7_sum",  {28'd0, sum}, 0);
        chk("g7_busy0", {31'd0, busy}, 0);
        chk("g7_rdy",  {31'd0, ready}, 0);
        chk("g7_rl",   {30'd0, rolls}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
